// File: rtl/pll_mode_switch.sv
// PLL reconfiguration sequencer: rewrites the fractional feedback K through the
// reconfig controller's Avalon-MM port to switch between NTSC and PAL core clocks,
// waits for relock and holds the downstream core in reset while the clock is unstable.
`timescale 1ns / 1ps

module pll_mode_switch #(
  parameter logic [31:0] K_NTSC       = 32'h96F21F6D,
  parameter logic [31:0] K_PAL        = 32'h8A3D70A4,
  parameter int unsigned UNLOCK_WAIT  = 256,
  parameter int unsigned LOCK_TIMEOUT = 1 << 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PAL,
  input  logic        PLL_LOCKED,
  output logic [5:0]  MGMT_ADDR,
  output logic [31:0] MGMT_WDATA,
  output logic        MGMT_WRITE,
  input  logic        MGMT_WAITREQ,
  output logic        CORE_HOLD,
  output logic        BUSY,
  output logic        PAL_ACTIVE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    StBoot, StIdle, StWrMode, StWrK, StWrStart, StWaitUnlock, StWaitLock, StRetry
  } state_e;

  // WAIT_UNLOCK spends UNLOCK_WAIT cycles at most, WAIT_LOCK spends LOCK_TIMEOUT.
  localparam logic [20:0] UnlockLast   = 21'(UNLOCK_WAIT - 1);
  localparam logic [20:0] LockLast     = 21'(LOCK_TIMEOUT - 1);
  localparam logic [20:0] SettleCycles = 21'd16;

  logic        pal_meta_q, pal_s_q, lock_meta_q, lock_s_q;
  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic        target_q, target_d;
  logic        retry_q, retry_d;
  logic        pal_active_q, pal_active_d;
  logic        err_q, err_d;
  logic        write_q, write_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;

  // Two-flop synchronizers for the asynchronous mode request and lock inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pal_meta_q  <= 1'b0;
      pal_s_q     <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      pal_meta_q  <= PAL;
      pal_s_q     <= pal_meta_q;
      lock_meta_q <= PLL_LOCKED;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state logic; every output is computed from the next state and registered.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    retry_d      = retry_q;
    pal_active_d = pal_active_q;
    err_d        = err_q;
    unique case (state_q)
      StBoot: begin
        if (lock_s_q) begin
          target_d = pal_s_q;
          state_d  = StWrMode;
        end
      end
      StIdle: begin
        if (pal_s_q != pal_active_q) begin
          target_d = pal_s_q;
          state_d  = StWrMode;
        end
      end
      StWrMode:  if (!MGMT_WAITREQ) state_d = StWrK;
      StWrK:     if (!MGMT_WAITREQ) state_d = StWrStart;
      StWrStart: if (!MGMT_WAITREQ) state_d = StWaitUnlock;
      StWaitUnlock: begin
        // A small K step may never drop lock, so expiry is a normal exit.
        if (!lock_s_q || cnt_q >= UnlockLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (lock_s_q) begin
          pal_active_d = target_q;
          retry_d      = 1'b0;
          state_d      = StIdle;
        end else if (cnt_q >= LockLast) begin
          state_d = StRetry;
        end
      end
      StRetry: begin
        if (!retry_q) begin
          retry_d = 1'b1;
          state_d = StWrMode;
        end else begin
          // Record the target as active so IDLE does not resequence forever.
          err_d        = 1'b1;
          pal_active_d = target_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StBoot;
    endcase

    cnt_d = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 21'd1);

    write_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      StWrMode: begin
        write_d = 1'b1;
        addr_d  = 6'h00;
        wdata_d = 32'd0;
      end
      StWrK: begin
        write_d = 1'b1;
        addr_d  = 6'h07;
        wdata_d = target_d ? K_PAL : K_NTSC;
      end
      StWrStart: begin
        write_d = 1'b1;
        addr_d  = 6'h02;
        wdata_d = 32'd1;
      end
      default: ;
    endcase

    busy_d = (state_d != StIdle);
    // In IDLE the state counter doubles as the post-lock settle counter.
    hold_d = busy_d || (cnt_d < SettleCycles);
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StBoot;
      cnt_q        <= '0;
      target_q     <= 1'b0;
      retry_q      <= 1'b0;
      pal_active_q <= 1'b0;
      err_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_q       <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      retry_q      <= retry_d;
      pal_active_q <= pal_active_d;
      err_q        <= err_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
    end
  end

  assign MGMT_ADDR  = addr_q;
  assign MGMT_WDATA = wdata_q;
  assign MGMT_WRITE = write_q;
  assign CORE_HOLD  = hold_q;
  assign BUSY       = busy_q;
  assign PAL_ACTIVE = pal_active_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_pll_mode_switch.sv
// Bench for pll_mode_switch: randomized stalls, PLL lock behaviour and mode requests,
// checked against the expected write list and timing rules of the sequencer.
`timescale 1ns / 1ps

module tb_pll_mode_switch;

  localparam logic [31:0] KNtsc  = 32'h96F21F6D;
  localparam logic [31:0] KPal   = 32'h8A3D70A4;
  localparam int unsigned LockTo = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pal = 1'b0;
  logic        lock = 1'b1;
  logic        waitreq = 1'b0;
  logic [5:0]  mgmt_addr;
  logic [31:0] mgmt_wdata;
  logic        mgmt_write, core_hold, busy, pal_active, err;

  pll_mode_switch #(.LOCK_TIMEOUT(LockTo)) dut (
    .CLK(clk), .RST_N(rst_n), .PAL(pal), .PLL_LOCKED(lock),
    .MGMT_ADDR(mgmt_addr), .MGMT_WDATA(mgmt_wdata), .MGMT_WRITE(mgmt_write),
    .MGMT_WAITREQ(waitreq), .CORE_HOLD(core_hold), .BUSY(busy),
    .PAL_ACTIVE(pal_active), .ERR(err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: completed writes expected for each programming sequence.
  logic [37:0] exp_q[$];
  logic [37:0] got_q[$];
  logic        pa_log[$];

  task automatic push_seq(input bit t);
    exp_q.push_back({6'h00, 32'd0});
    exp_q.push_back({6'h07, t ? KPal : KNtsc});
    exp_q.push_back({6'h02, 32'd1});
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_addr"}, 64'(got_q[i][37:32]), 64'(exp_q[i][37:32]));
      check({tag, "_data"}, 64'(got_q[i][31:0]), 64'(exp_q[i][31:0]));
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  event        start_ev;
  bit          pend = 0, done_last = 0, prev_busy = 1, prev_hold = 1;
  logic [5:0]  p_addr;
  logic [31:0] p_data;
  int          run_len = 0, last_run = 0, last_wr_edge = 0, busy_fall_cyc = 0;

  always @(negedge clk) begin
    done_last = 0;
    if (!rst_n) begin
      pend = 0;
      run_len = 0;
      prev_busy = 1;
      prev_hold = 1;
    end else begin
      if (mgmt_write) begin
        if (pend) begin
          check("addr_stable", 64'(mgmt_addr), 64'(p_addr));
          check("data_stable", 64'(mgmt_wdata), 64'(p_data));
        end
        check("write_while_busy", 64'(busy), 64'd1);
        run_len++;
        p_addr = mgmt_addr;
        p_data = mgmt_wdata;
        if (!waitreq) begin
          got_q.push_back({mgmt_addr, mgmt_wdata});
          pend = 0;
          done_last = 1;
          last_wr_edge = cyc + 1;
          if (mgmt_addr == 6'h02) ->start_ev;
        end else begin
          pend = 1;
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        pend = 0;
      end
      if (prev_busy && !busy) begin
        busy_fall_cyc = cyc;
        pa_log.push_back(pal_active);
      end
      if (prev_hold && !core_hold) check("settle16", 64'(cyc - busy_fall_cyc), 64'd16);
      prev_busy = busy;
      prev_hold = core_hold;
    end
  end

  // Waitrequest driver: stall_len stall cycles at the start of each write.
  int stall_cnt = 0, stall_len = 0, stall_max = 0;
  bit stall_rand = 0;
  always @(posedge clk) begin
    #1;
    if (!mgmt_write) begin
      stall_cnt = 0;
      waitreq = 1'($urandom_range(0, 1));
      stall_len = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
    end else begin
      if (done_last) begin
        stall_cnt = 0;
        stall_len = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
      end
      waitreq = (stall_cnt < stall_len);
      stall_cnt++;
    end
  end

  // PLL model: 0 = drops then relocks, 1 = never drops lock, 2 = loses lock for good.
  int pll_mode = 0, fix_drop = 0, fix_rise = 0;
  always begin
    @(start_ev);
    if (pll_mode == 2) begin
      lock = 1'b0;
    end else if (pll_mode == 0) begin
      repeat (fix_drop != 0 ? fix_drop : int'($urandom_range(2, 20))) @(posedge clk);
      #2 lock = 1'b0;
      repeat (fix_rise != 0 ? fix_rise : int'($urandom_range(10, 200))) @(posedge clk);
      #2 lock = 1'b1;
    end
  end

  task automatic settle(input int n, input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got_q.size() >= n && !busy && !core_hold) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_done"}, 64'(ok), 64'd1);
  endtask

  task automatic request(input bit t);
    @(posedge clk);
    #1 pal = t;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_write"}, 64'(mgmt_write), 64'd0);
    check({tag, "_addr"}, 64'(mgmt_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mgmt_wdata), 64'd0);
    check({tag, "_hold"}, 64'(core_hold), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_pal_active"}, 64'(pal_active), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  bit cur, p0, np0, seen;
  int lat, n_before;

  initial begin
    // Power-on boot with PAL=0 and no stalls.
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_seq(1'b0);
    settle(3, 2000, "boot");
    cmp_writes("boot");
    check("boot_run3", 64'(last_run), 64'd3);
    check("boot_pal_active", 64'(pal_active), 64'd0);
    check("boot_busy", 64'(busy), 64'd0);
    check("boot_err", 64'(err), 64'd0);

    // Switch to PAL with 5 stall cycles on every write.
    stall_max = 5;
    got_q.delete(); exp_q.delete();
    push_seq(1'b1);
    request(1'b1);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (mgmt_write) begin
        seen = 1;
        break;
      end
    end
    check("write_latency_3or4", 64'(seen && (lat == 3 || lat == 4)), 64'd1);
    settle(3, 3000, "pal");
    cmp_writes("pal");
    check("pal_active1", 64'(pal_active), 64'd1);
    cur = 1'b1;

    // Random mode toggles with random stalls and lock behaviour.
    stall_rand = 1;
    stall_max = 3;
    for (int it = 0; it < 6; it++) begin
      cur = !cur;
      got_q.delete(); exp_q.delete();
      push_seq(cur);
      request(cur);
      settle(3, 3000, "rand");
      cmp_writes("rand");
      check("rand_pal_active", 64'(pal_active), 64'(cur));
      check("rand_err", 64'(err), 64'd0);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    // Lock never drops: WAIT_UNLOCK runs 256 cycles, WAIT_LOCK exits one cycle later.
    stall_rand = 0;
    stall_max = 0;
    pll_mode = 1;
    cur = !cur;
    got_q.delete(); exp_q.delete();
    push_seq(cur);
    request(cur);
    settle(3, 3000, "stuck");
    cmp_writes("stuck");
    check("unlock_expiry", 64'(busy_fall_cyc - last_wr_edge), 64'd257);
    check("stuck_err", 64'(err), 64'd0);
    check("stuck_pal_active", 64'(pal_active), 64'(cur));

    // Request flips back during WAIT_LOCK: first sequence completes, then a second runs.
    pll_mode = 0;
    fix_drop = 5;
    fix_rise = 100;
    p0 = cur;
    np0 = !p0;
    got_q.delete(); exp_q.delete(); pa_log.delete();
    push_seq(np0);
    push_seq(p0);
    request(np0);
    for (int i = 0; i < 500 && got_q.size() < 3; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    pal = p0;
    settle(6, 4000, "flip");
    cmp_writes("flip");
    check("flip_idle_visits", 64'(pa_log.size()), 64'd2);
    if (pa_log.size() >= 1) check("flip_first_active", 64'(pa_log[0]), 64'(np0));
    check("flip_final_active", 64'(pal_active), 64'(p0));
    fix_drop = 0;
    fix_rise = 0;

    // Lock lost for good: two full sequences, then sticky error and no more writes.
    pll_mode = 2;
    cur = np0;
    got_q.delete(); exp_q.delete();
    push_seq(cur);
    push_seq(cur);
    request(cur);
    settle(6, 6000, "dead");
    cmp_writes("dead");
    check("dead_err", 64'(err), 64'd1);
    check("dead_busy", 64'(busy), 64'd0);
    check("dead_pal_active", 64'(pal_active), 64'(cur));
    n_before = got_q.size();
    repeat (60) @(negedge clk);
    check("dead_no_more_writes", 64'(got_q.size()), 64'(n_before));

    // Reset while the K write is stalled; BOOT reprograms the current request.
    pll_mode = 0;
    lock = 1'b1;
    stall_max = 20;
    cur = !cur;
    got_q.delete(); exp_q.delete();
    request(cur);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mgmt_write && mgmt_addr == 6'h07) begin
        seen = 1;
        break;
      end
    end
    check("reached_wr_k", 64'(seen), 64'd1);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    got_q.delete();
    push_seq(cur);
    stall_max = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle(3, 2000, "reboot");
    cmp_writes("reboot");
    check("reboot_pal_active", 64'(pal_active), 64'(cur));
    check("reboot_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pll_mode_switch.md
# pll_mode_switch

Reconfiguration sequencer that sits directly upstream of the system PLL's `reconfig_to_pll` path. It drives the Avalon-MM management port of the PLL reconfiguration controller. It rewrites the fractional feedback value K to move the core clock between NTSC (53.6852 MHz) and PAL (53.375 MHz) rates, then waits for lock. It also holds the core in reset while the clock is unstable.

## Interface
- `K_NTSC`, default 32'h96F21F6D: fractional K for VCO 429.4816 MHz, with M=8 and N bypassed.
- `K_PAL`, default 32'h8A3D70A4: fractional K for VCO 427.0 MHz.
- `UNLOCK_WAIT`, default 256: cycles allowed for `PLL_LOCKED` to fall after start.
- `LOCK_TIMEOUT`, default 2^20: cycles allowed for `PLL_LOCKED` to rise.

Ports:
- `CLK` in 1: 50 MHz reference-domain clock; one clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `PAL` in 1: requested mode, asynchronous; 1 = PAL.
- `PLL_LOCKED` in 1: PLL lock, asynchronous.
- `MGMT_ADDR` out 6: reconfig controller register address.
- `MGMT_WDATA` out 32: write data.
- `MGMT_WRITE` out 1: write strobe.
- `MGMT_WAITREQ` in 1: controller stall.
- `CORE_HOLD` out 1: holds the downstream core in reset.
- `BUSY` out 1: a sequence is in progress.
- `PAL_ACTIVE` out 1: mode last programmed successfully.
- `ERR` out 1: sticky lock failure, cleared only by reset.

## Operation
- `PAL` and `PLL_LOCKED` each pass through a 2-FF synchronizer. All decisions use the synchronized versions `pal_s` and `lock_s`.
- FSM states: BOOT, IDLE, WR_MODE, WR_K, WR_START, WAIT_UNLOCK, WAIT_LOCK, RETRY.
- BOOT:
  - Wait for `lock_s`=1, unbounded.
  - Latch `target` = `pal_s`, then go to WR_MODE.
  - Every reset therefore reprograms the PLL once, so a reconfig interrupted by reset is recovered.
- IDLE: if `pal_s` != `PAL_ACTIVE`, latch `target` = `pal_s` and go to WR_MODE.
- WR_MODE: addr 0x00, data 0 (waitrequest mode).
- WR_K: addr 0x07, data = `target` ? `K_PAL` : `K_NTSC`.
- WR_START: addr 0x02, data 1.
- Write handshake:
  - In each WR state, `MGMT_WRITE`=1 with stable addr and data.
  - The write completes on the first rising edge where `MGMT_WAITREQ`=0.
  - The FSM advances on that edge.
- WAIT_UNLOCK:
  - Counter counts up to `UNLOCK_WAIT`.
  - Leave when `lock_s`=0 or when the counter expires; expiry is legal because a small K change may not drop lock.
  - Go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - On `lock_s`=1: set `PAL_ACTIVE` = `target`, clear the retry flag, go to IDLE.
  - On counter = `LOCK_TIMEOUT`-1 with no lock: go to RETRY.
- RETRY:
  - If the retry flag is clear: set it and go to WR_MODE (full resequence).
  - Otherwise: set `ERR`, set `PAL_ACTIVE` = `target`, go to IDLE.
  - IDLE does not then loop, because `pal_s` == `PAL_ACTIVE`.
- `PAL` changes mid-sequence are ignored until IDLE; IDLE re-compares, so the final `PAL` value always wins.
- `BUSY` = 1 in every state except IDLE.
- `CORE_HOLD` = 1 in every state except IDLE, and additionally for 16 cycles after entering IDLE, via a post-lock settle counter.
- Counters: 21-bit, saturating, cleared on every state entry.

## Timing
- Reset values:
  - State BOOT.
  - `MGMT_WRITE`=0, `MGMT_ADDR`=0, `MGMT_WDATA`=0.
  - `CORE_HOLD`=1, `BUSY`=1, `PAL_ACTIVE`=0, `ERR`=0.
  - Counters 0, retry flag 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Input-to-decision latency is 2 cycles (synchronizer). From a `PAL` toggle in IDLE, `MGMT_WRITE` rises in cycle 3 or 4.
- Minimum sequence with `MGMT_WAITREQ`=0 throughout: 3 write cycles, then WAIT_UNLOCK/WAIT_LOCK. `MGMT_WRITE` is high for exactly 3 consecutive cycles.
- `MGMT_WRITE` deasserts on the edge that completes WR_START. It is never high outside the WR states.
- Reset mid-write drops `MGMT_WRITE` asynchronously. The sequence restarts from BOOT.
- Simultaneous `lock_s` rise and timeout expiry in WAIT_LOCK: lock wins.

## Test plan
- Reset, PLL_LOCKED=1, PAL=0, WAITREQ=0 → 3 writes: (0x00, 0), (0x07, 0x96F21F6D), (0x02, 1). After lock and 16 cycles, CORE_HOLD=0, BUSY=0, PAL_ACTIVE=0.
- In IDLE, PAL 0→1 with WAITREQ held high 5 cycles per write → each write's addr/data stays stable until WAITREQ=0, with K write 0x8A3D70A4. PAL_ACTIVE=1 after lock returns.
- PLL_LOCKED stays 1 throughout → WAIT_UNLOCK expires after 256 cycles, then WAIT_LOCK exits the next cycle. ERR=0.
- PLL_LOCKED held 0 after start → two full sequences (6 writes), then ERR=1, BUSY=0, and no further writes.
- PAL toggled 1 then back to 0 during WAIT_LOCK → the first sequence completes with PAL_ACTIVE=1, and a second sequence writes K_NTSC.
- RST_N asserted during WR_K with WAITREQ=1 → MGMT_WRITE=0 immediately, all outputs at reset values. On release, BOOT reprograms the current PAL target.
